// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial-to-parallel UART receiver.
//
// The asynchronous rx line passes through a two-flop synchroniser. A falling
// edge starts a frame. The start bit is re-checked at its midpoint so that
// short glitches are rejected. Each data bit, LSB first, is then sampled one
// full bit period after the previous sample. A high stop bit publishes the
// byte. A low stop bit raises a framing error and parks the FSM until the
// line returns high.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial line, asynchronous to clk, idle high
//   rx_data    last correctly received byte (held until the next good frame)
//   rx_valid   one-cycle pulse, rx_data is new this cycle
//   frame_err  one-cycle pulse, stop bit was sampled low
//   busy       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cyc_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            rx_p0;
    logic            rx_s;

    // ---- synchroniser stage: rx -> rx_p0 -> rx_s ----
    // Both flops reset to the idle level so reset release cannot look like a
    // start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // ---- frame FSM stage: decisions on rx_s only, outputs registered ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (cyc_cnt == CYC_HALF) begin
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            // Line went back high before mid-start: a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cyc_cnt == CYC_LAST) begin
                        // Sampling is now centred on each data bit, one full
                        // period after the mid-start sample.
                        shreg   <= {rx_s, shreg[7:1]};
                        cyc_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            // Returning to IDLE at the stop midpoint lets a
                            // start bit right after the stop bit be caught.
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK_WAIT;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                BRK_WAIT: begin
                    // A held-low line must not be decoded as a stream of
                    // 0x00 frames, so wait for the idle level first.
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-parallel UART receiver and the receive-side counterpart of the team's PISO transmitter. Frame format is 8N1:
- line idles high
- one low start bit
- 8 data bits, LSB first
- one high stop bit

The block synchronises the asynchronous rx line, detects the start edge and samples each bit at its midpoint. It presents the byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit period; legal values are 4 and above. The mid-bit point is CLKS_PER_BIT/2 (integer division).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
rx_data  output  8  last correctly received byte
rx_valid  output  1  one-cycle pulse; rx_data is new this cycle
frame_err  output  1  one-cycle pulse; stop bit was sampled low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
Reset (rst_n low, asynchronous):
- FSM goes to IDLE.
- Bit counter, cycle counter and shift register go to 0.
- rx_data = 8'h00; rx_valid = 0; frame_err = 0; busy = 0.
- Synchroniser flops are set to 1, so no false start is seen on reset release.
- Reset asserted mid-frame aborts the frame. No valid or error pulse is produced, and rx_data keeps the reset value.

Synchroniser:
- Two-flop synchroniser on rx; its output is rx_s.
- All FSM decisions use rx_s only.
- This adds 2 cycles of latency.

Counters:
- cyc_cnt counts 0..CLKS_PER_BIT-1.
- bit_idx counts 0..7.

FSM states:
- IDLE:
  - busy = 0.
  - When rx_s = 0, go to START with cyc_cnt = 0.
- START:
  - When cyc_cnt reaches CLKS_PER_BIT/2 - 1, sample rx_s.
  - If rx_s = 1, it was a glitch: return to IDLE with no pulse.
  - If rx_s = 0, go to DATA with cyc_cnt = 0 and bit_idx = 0.
- DATA:
  - When cyc_cnt reaches CLKS_PER_BIT-1, this is the midpoint of the current data bit. Shift rx_s in from the MSB side (shreg <= {rx_s, shreg[7:1]}) and reset cyc_cnt.
  - After bit_idx = 7 is sampled, go to STOP with cyc_cnt = 0.
- STOP:
  - When cyc_cnt reaches CLKS_PER_BIT-1, this is the stop-bit midpoint.
  - If rx_s = 1: load rx_data from shreg, pulse rx_valid for exactly 1 cycle, go to IDLE.
  - If rx_s = 0: pulse frame_err for 1 cycle, leave rx_data unchanged, go to BRK_WAIT.
- BRK_WAIT:
  - Stay here while rx_s = 0.
  - When rx_s = 1, go to IDLE.
  - This prevents a break condition or a stuck-low line from being decoded as repeated 0x00 frames.

Pulse timing:
- rx_valid and frame_err are registered outputs.
- They assert on the clock edge following the stop-bit sample.
- They are never high together.

Latency:
- rx_valid rises about 9.5 bit periods + 3 clk cycles after the rx start edge.
- This figure covers the 2-cycle synchroniser, the IDLE detect cycle and the sampling register.
- The exact value must be a constant and must be documented in the bench.

Back-to-back frames:
- IDLE is re-entered at the stop-bit midpoint, so a start bit that immediately follows a stop bit is detected.
- No idle gap is required between frames.

Other rules:
- rx_data holds its value until the next good frame.
- rx_valid is informational only; there is no ready back-pressure, and an unread byte is overwritten.
- bit_idx and cyc_cnt saturate-free wrap is not allowed. Every counter is explicitly cleared on each state transition.

Test Plan:
1. CLKS_PER_BIT=16, reset then send 0xA5 framed as 0,1,0,1,0,0,1,0,1,1 → exactly one rx_valid pulse, rx_data = 8'hA5, frame_err never high, busy high throughout the frame only.
2. Send 0x00 immediately followed by 0xFF with no idle gap → two rx_valid pulses exactly 10×16 cycles apart; rx_data = 8'h00, then 8'hFF.
3. Drive rx low for 4 cycles then high (start glitch) → FSM returns to IDLE, no rx_valid or frame_err, rx_data unchanged; a following 0x3C is received correctly.
4. Send 0x5A with the stop bit driven low, hold rx low for 40 more bit periods, then release high → one frame_err pulse, no rx_valid, rx_data keeps its previous value, busy high until the line returns high. A subsequent 0x81 is then received correctly.
5. Assert rst_n low mid-DATA (after 4 bits of 0xC3), release it, then send 0x7E → no pulse from the aborted frame; all outputs are at reset values during reset; rx_data = 8'h7E afterwards.
6. CLKS_PER_BIT=4, send 0x96 → rx_data = 8'h96 with one rx_valid pulse. This confirms the parameterised mid-bit sampling is correct at the minimum legal value.
